// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads IRAM, pairs opcodes with inline operands, issues over valid/ready.
// Optional issue counter output enabled by defining FETCH_ISSUE_CNT_EN.
module instr_fetch #(
    parameter int                 ADDR_W   = 16,
    parameter int                 DATA_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] iram_addr,
    input  logic [DATA_W-1:0] iram_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_opcode,
    output logic [DATA_W-1:0] instr_operand,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
`ifdef FETCH_ISSUE_CNT_EN
    output logic [15:0]       issue_count,
`endif
    output logic              halted
);

    typedef enum logic [2:0] {
        ST_FETCH_OP  = 3'd0,
        ST_LATCH_OP  = 3'd1,
        ST_FETCH_ARG = 3'd2,
        ST_LATCH_ARG = 3'd3,
        ST_ISSUE     = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    localparam logic [DATA_W-1:0] OP_LDAC  = DATA_W'(32'd7);
    localparam logic [DATA_W-1:0] OP_STAC  = DATA_W'(32'd11);
    localparam logic [DATA_W-1:0] OP_JUMP  = DATA_W'(32'd33);
    localparam logic [DATA_W-1:0] OP_JPNZ  = DATA_W'(32'd35);
    localparam logic [DATA_W-1:0] OP_ENDOP = DATA_W'(32'd40);
    localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_opcode;
    logic [DATA_W-1:0] r_operand;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_valid;
    logic              r_halted;
    logic              w_fire;

    function automatic logic f_has_operand(input logic [DATA_W-1:0] op);
        logic res;
        case (op)
            OP_LDAC, OP_STAC, OP_JUMP, OP_JPNZ: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

    assign w_fire        = r_valid && instr_ready;
    assign iram_addr     = r_pc;
    assign instr_valid   = r_valid;
    assign instr_opcode  = r_opcode;
    assign instr_operand = r_operand;
    assign instr_pc      = r_instr_pc;
    assign halted        = r_halted;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH_OP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; redirect overrides every state
    always_comb begin
        w_state_nxt = r_state;
        if (redirect) begin
            w_state_nxt = ST_FETCH_OP;
        end else begin
            case (r_state)
                ST_FETCH_OP:  w_state_nxt = ST_LATCH_OP;
                ST_LATCH_OP:  w_state_nxt = f_has_operand(iram_data) ? ST_FETCH_ARG : ST_ISSUE;
                ST_FETCH_ARG: w_state_nxt = ST_LATCH_ARG;
                ST_LATCH_ARG: w_state_nxt = ST_ISSUE;
                ST_ISSUE: begin
                    if (instr_ready) begin
                        w_state_nxt = (r_opcode == OP_ENDOP) ? ST_HALT : ST_FETCH_OP;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
                ST_HALT:      w_state_nxt = ST_HALT;
                default:      w_state_nxt = ST_FETCH_OP;
            endcase
        end
    end

    // PC, instruction capture and registered handshake/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_opcode   <= {DATA_W{1'b0}};
            r_operand  <= {DATA_W{1'b0}};
            r_instr_pc <= {ADDR_W{1'b0}};
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_valid  <= (w_state_nxt == ST_ISSUE);
            r_halted <= (w_state_nxt == ST_HALT);
            if (redirect) begin
                r_pc <= redirect_pc;
            end else if (r_state == ST_LATCH_OP) begin
                r_opcode   <= iram_data;
                r_operand  <= {DATA_W{1'b0}};
                r_instr_pc <= r_pc;
                r_pc       <= r_pc + PC_ONE;
            end else if (r_state == ST_LATCH_ARG) begin
                r_operand <= iram_data;
                r_pc      <= r_pc + PC_ONE;
            end else begin
                r_pc <= r_pc;
            end
        end
    end

`ifdef FETCH_ISSUE_CNT_EN
    logic [15:0] r_issue_count;

    // Accepted-instruction counter; a redirect does not clear it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_count <= 16'd0;
        end else if (w_fire) begin
            r_issue_count <= r_issue_count + 16'd1;
        end else begin
            r_issue_count <= r_issue_count;
        end
    end

    assign issue_count = r_issue_count;
`else
    logic w_unused_fire;
    assign w_unused_fire = w_fire;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: program issue, backpressure, redirect, PC wrap, halt, reset abort.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] iram_addr, iram_addr2;
    logic [15:0] iram_data, iram_data2;
    logic        instr_valid, instr_valid2;
    logic        instr_ready;
    logic [15:0] instr_opcode, instr_opcode2;
    logic [15:0] instr_operand, instr_operand2;
    logic [15:0] instr_pc, instr_pc2;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted, halted2;
`ifdef FETCH_ISSUE_CNT_EN
    logic [15:0] issue_count, issue_count2;
`endif

    logic [15:0] ram [0:65535];
    int vec_cnt = 0;
    int err_cnt = 0;

    instr_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst(rst), .iram_addr(iram_addr), .iram_data(iram_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_operand(instr_operand), .instr_pc(instr_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
`ifdef FETCH_ISSUE_CNT_EN
        .issue_count(issue_count),
`endif
        .halted(halted)
    );

    instr_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFF)) u_dut_wrap (
        .clk(clk), .rst(rst), .iram_addr(iram_addr2), .iram_data(iram_data2),
        .instr_valid(instr_valid2), .instr_ready(1'b1),
        .instr_opcode(instr_opcode2), .instr_operand(instr_operand2), .instr_pc(instr_pc2),
        .redirect(1'b0), .redirect_pc(16'h0000),
`ifdef FETCH_ISSUE_CNT_EN
        .issue_count(issue_count2),
`endif
        .halted(halted2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous IRAM models, one-cycle read latency
    always @(posedge clk) begin
        iram_data  <= ram[iram_addr];
        iram_data2 <= (iram_addr2 == 16'hFFFF) ? 16'd7 : ((iram_addr2 == 16'h0000) ? 16'd99 : 16'd0);
    end

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 20);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk_vec("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk_vec("rst_addr", {16'd0, iram_addr}, 32'd0);
        chk_vec("rst_halted", {31'd0, halted}, 32'd0);
        chk_vec("rst_opcode", {16'd0, instr_opcode}, 32'd0);
        chk_vec("rst_operand", {16'd0, instr_operand}, 32'd0);
        chk_vec("rst_pc", {16'd0, instr_pc}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic chk_instr(input string tag, input int op, input int arg, input int pc);
        chk_vec({tag, "_opcode"}, {16'd0, instr_opcode}, op);
        chk_vec({tag, "_operand"}, {16'd0, instr_operand}, arg);
        chk_vec({tag, "_pc"}, {16'd0, instr_pc}, pc);
    endtask

    int exp_op  [6] = '{7, 15, 7, 26, 11, 40};
    int exp_arg [6] = '{130, 0, 135, 0, 65400, 0};
    int exp_pc  [6] = '{0, 2, 3, 5, 6, 8};
    int exp_gap [6] = '{4, 3, 5, 3, 5, 3};

    initial begin
        int n;
        rst         = 1'b1;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        for (int a = 0; a < 65536; a++) ram[a] = 16'd0;
        ram[0] = 16'd7;  ram[1] = 16'd130; ram[2] = 16'd15;
        ram[3] = 16'd7;  ram[4] = 16'd135; ram[5] = 16'd26;
        ram[6] = 16'd11; ram[7] = 16'd65400; ram[8] = 16'd40;
        repeat (2) @(negedge clk);

        // Full program with ready high; wrap instance released by the same reset
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wait_valid(n);
            chk_vec($sformatf("prog%0d_gap", i), n, exp_gap[i]);
            chk_instr($sformatf("prog%0d", i), exp_op[i], exp_arg[i], exp_pc[i]);
            if (i == 0) begin
                chk_vec("wrap_valid", {31'd0, instr_valid2}, 32'd1);
                chk_vec("wrap_opcode", {16'd0, instr_opcode2}, 32'd7);
                chk_vec("wrap_operand", {16'd0, instr_operand2}, 32'd99);
                chk_vec("wrap_pc", {16'd0, instr_pc2}, 32'hFFFF);
                chk_vec("wrap_next_addr", {16'd0, iram_addr2}, 32'd1);
            end
        end
        @(negedge clk);
        chk_vec("halt_flag", {31'd0, halted}, 32'd1);
        chk_vec("halt_valid", {31'd0, instr_valid}, 32'd0);
        chk_vec("halt_addr", {16'd0, iram_addr}, 32'd9);
        repeat (3) @(negedge clk);
        chk_vec("halt_stay", {31'd0, halted}, 32'd1);
        chk_vec("halt_pc_frozen", {16'd0, iram_addr}, 32'd9);

        // Redirect out of HALT
        redirect    = 1'b1;
        redirect_pc = 16'd0;
        @(negedge clk);
        redirect = 1'b0;
        chk_vec("unhalt_flag", {31'd0, halted}, 32'd0);
        chk_vec("unhalt_addr", {16'd0, iram_addr}, 32'd0);
        wait_valid(n);
        chk_vec("unhalt_gap", n, 32'd4);
        chk_instr("unhalt", 7, 130, 0);

        // Reset pulse during ISSUE aborts at once
        rst = 1'b1;
        #1;
        chk_vec("rstmid_valid", {31'd0, instr_valid}, 32'd0);
        chk_vec("rstmid_addr", {16'd0, iram_addr}, 32'd0);
        chk_vec("rstmid_addr_wrap", {16'd0, iram_addr2}, 32'hFFFF);
        @(negedge clk);
        rst = 1'b0;
        wait_valid(n);
        chk_vec("rstmid_gap", n, 32'd4);
        chk_instr("rstmid", 7, 130, 0);

        // Backpressure: ready low for 6 cycles at first issue
        instr_ready = 1'b0;
        do_reset();
        wait_valid(n);
        chk_vec("bp_first_gap", n, 32'd4);
        for (int c = 0; c < 6; c++) begin
            chk_vec($sformatf("bp_hold%0d_valid", c), {31'd0, instr_valid}, 32'd1);
            chk_instr($sformatf("bp_hold%0d", c), 7, 130, 0);
            chk_vec($sformatf("bp_hold%0d_addr", c), {16'd0, iram_addr}, 32'd2);
            @(negedge clk);
        end
        instr_ready = 1'b1;
        wait_valid(n);
        chk_vec("bp_second_gap", n, 32'd3);
        chk_instr("bp_second", 15, 0, 2);

        // Redirect to 3 during LATCH_ARG of the first LDAC
        do_reset();
        repeat (3) @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 16'd3;
        @(negedge clk);
        redirect = 1'b0;
        chk_vec("redir_valid", {31'd0, instr_valid}, 32'd0);
        chk_vec("redir_addr", {16'd0, iram_addr}, 32'd3);
        wait_valid(n);
        chk_vec("redir_gap", n, 32'd4);
        chk_instr("redir", 7, 135, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit that reads from the IRAM instruction memory and delivers decoded instruction words to the core. It drives the IRAM address, absorbs the IRAM's one-cycle synchronous read latency and pairs each opcode with its inline operand word when the opcode carries one. It then issues {opcode, operand, pc} to the execution core over a valid/ready handshake. It handles branch redirects and halts on ENDOP.

## Interface
- ADDR_W, 16, IRAM address width / PC width
- DATA_W, 16, IRAM word width
- RESET_PC, 0, PC loaded on reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- iram_addr  out  ADDR_W  IRAM read address (registered, equals PC)
- iram_data  in  DATA_W  IRAM read data, valid one cycle after iram_addr is sampled
- instr_valid  out  1  issued instruction valid
- instr_ready  in  1  core accepts instruction
- instr_opcode  out  DATA_W  opcode word
- instr_operand  out  DATA_W  operand word; 0 for opcodes without an operand
- instr_pc  out  ADDR_W  address of the opcode word
- redirect  in  1  load new PC (taken JUMP/JPNZ), flush in-flight fetch
- redirect_pc  in  ADDR_W  redirect target
- halted  out  1  ENDOP issued and accepted; fetch stopped

## Operation
- Operand-carrying opcodes: LDAC=7, STAC=11, JUMP=33, JPNZ=35. All other values, including unknown ones, are single-word instructions.
- State FETCH_OP: iram_addr=pc. Next state is LATCH_OP.
- State LATCH_OP: capture iram_data into the opcode and set instr_pc=pc, pc<=pc+1.
  - If the opcode carries an operand, go to FETCH_ARG.
  - Otherwise set operand=0 and go to ISSUE.
- State FETCH_ARG: iram_addr=pc. Next state is LATCH_ARG.
- State LATCH_ARG: capture iram_data into the operand, pc<=pc+1. Next state is ISSUE.
- State ISSUE: instr_valid=1. On valid&&ready:
  - go to FETCH_OP;
  - if the opcode is ENDOP=40, go to HALT instead.
- State HALT: halted=1, instr_valid=0, pc frozen. Only redirect or rst leaves HALT.
- Redirect (any state, highest priority):
  - pc<=redirect_pc, next state FETCH_OP, halted<=0.
  - Any partially fetched instruction is discarded and instr_valid drops the next cycle.
- PC arithmetic is modulo 2^ADDR_W: 0xFFFF+1 wraps to 0x0000. An operand may sit at address 0 after an opcode at 0xFFFF.

## Timing
- Reset values: iram_addr=RESET_PC, instr_valid=0, instr_opcode=0, instr_operand=0, instr_pc=0, halted=0. State is FETCH_OP.
- Reset asserted mid-fetch or mid-issue aborts immediately. There is no partial issue after reset release.
- Latency from entering FETCH_OP to instr_valid: 2 cycles for single-word instructions, 4 cycles for operand instructions.
- Throughput with ready held high: 3 cycles per single-word instruction, 5 cycles per operand instruction. No pipelining across instructions.
- While valid&&!ready, instr_opcode, instr_operand and instr_pc hold stable. iram_addr holds the next PC.
- Simultaneous valid&&ready and redirect: the current instruction counts as transferred, and the redirect sets the PC.
- The redirect takes effect on the edge where it is sampled. The next iram_addr is redirect_pc.

## Configuration
- FETCH_ISSUE_CNT_EN defined:
  - adds output issue_count [15:0], which increments on each valid&&ready and wraps 0xFFFF to 0;
  - issue_count resets to 0 and is unaffected by redirect.
- FETCH_ISSUE_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Program {7,130,15,7,135,26,11,65400,40} at address 0, ready=1.
  - Issues (7,130,pc0), (15,0,pc2), (7,135,pc3), (26,0,pc5), (11,65400,pc6), (40,0,pc8).
  - First valid in cycle 4 after reset release. halted=1 the cycle after ENDOP is accepted.
- Same program, ready held 0 for 6 cycles at the first issue:
  - valid stays high with outputs frozen at (7,130,0);
  - the second instruction appears 3 cycles after ready rises.
- Redirect to 3 asserted during LATCH_ARG of the first LDAC:
  - LDAC 130 is never issued;
  - the next issue is (7,135,pc3).
- RESET_PC=0xFFFF with ram[0xFFFF]=7, ram[0]=99:
  - issues (7,99,pc0xFFFF);
  - the next fetch address is 0x0001.
- In HALT, redirect to 0:
  - halted drops;
  - the program is re-fetched from address 0.
- rst pulsed during ISSUE:
  - instr_valid=0 and iram_addr=RESET_PC immediately;
  - fetch restarts from RESET_PC after release.
